// File: rtl/rs_add.sv
// rs_add_pkg: decoded-op payload and opcode constants shared by the station and its users.
// rs_add: reservation station for the integer add/logic FU.
//   Ops wait in a collapsing queue (slot 0 oldest) until both sources are ready.
//   Sources are woken by CDB broadcasts. The oldest ready op is offered to the FU.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     flush               squash every held op
//     dispatch_*          incoming op, its source/dest tags, ROB index, valid/ready
//     cdb_valid, cdb_pd   writeback broadcast used for wakeup
//     issue_*             oldest ready op, its tags, ROB index, valid/ready to the FU
package rs_add_pkg;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] pc;
    } decode_info_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

module rs_add
    import rs_add_pkg::*;
#(
    parameter int unsigned PHYS_REG_BITS = 6,
    parameter int unsigned ROB_IDX_BITS  = 5,
    parameter int unsigned NUM_ENTRIES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  decode_info_t             dispatch_info,
    input  logic [PHYS_REG_BITS-1:0] dispatch_ps1,
    input  logic                     dispatch_ps1_rdy,
    input  logic [PHYS_REG_BITS-1:0] dispatch_ps2,
    input  logic                     dispatch_ps2_rdy,
    input  logic [PHYS_REG_BITS-1:0] dispatch_pd,
    input  logic [ROB_IDX_BITS-1:0]  dispatch_rob,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output decode_info_t             issue_info,
    output logic [PHYS_REG_BITS-1:0] issue_ps1,
    output logic [PHYS_REG_BITS-1:0] issue_ps2,
    output logic [PHYS_REG_BITS-1:0] issue_pd,
    output logic [ROB_IDX_BITS-1:0]  issue_rob
);

    localparam int unsigned IW = $clog2(NUM_ENTRIES);
    localparam int unsigned CW = $clog2(NUM_ENTRIES + 1);

    typedef struct packed {
        decode_info_t             info;
        logic [PHYS_REG_BITS-1:0] ps1;
        logic                     rdy1;
        logic [PHYS_REG_BITS-1:0] ps2;
        logic                     rdy2;
        logic [PHYS_REG_BITS-1:0] pd;
        logic [ROB_IDX_BITS-1:0]  rob;
    } entry_t;

    entry_t         ent   [NUM_ENTRIES];
    entry_t         ent_n [NUM_ENTRIES];
    entry_t         woke  [NUM_ENTRIES];
    entry_t         new_ent;
    entry_t         sel_ent;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic [CW-1:0]  wr_idx;
    logic [IW-1:0]  sel;
    logic           found;
    logic           accept;
    logic           fire;
    logic           is_upper;
    logic           is_rr;

    // Occupancy from registered count only; a slot freed by issue is reusable next cycle.
    assign dispatch_ready = (cnt < CW'(NUM_ENTRIES));
    assign accept         = dispatch_valid && dispatch_ready;
    assign fire           = issue_valid && issue_ready;

    // Oldest ready entry; payload is zero when nothing is ready.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_ent = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!found && (CW'(i) < cnt) && ent[i].rdy1 && ent[i].rdy2) begin
                found   = 1'b1;
                sel     = IW'(i);
                sel_ent = ent[i];
            end
        end
    end

    assign issue_valid = found;
    assign issue_info  = sel_ent.info;
    assign issue_ps1   = sel_ent.ps1;
    assign issue_ps2   = sel_ent.ps2;
    assign issue_pd    = sel_ent.pd;
    assign issue_rob   = sel_ent.rob;

    // Incoming entry; upper-immediate ops ignore both sources, only reg-reg waits on ps2.
    always_comb begin
        is_upper         = (dispatch_info.opcode == OPC_LUI) || (dispatch_info.opcode == OPC_AUIPC);
        is_rr            = (dispatch_info.opcode == OPC_OP);
        new_ent          = '0;
        new_ent.info     = dispatch_info;
        new_ent.ps1      = dispatch_ps1;
        new_ent.ps2      = dispatch_ps2;
        new_ent.pd       = dispatch_pd;
        new_ent.rob      = dispatch_rob;
        new_ent.rdy1     = is_upper || dispatch_ps1_rdy || (dispatch_ps1 == '0) ||
                           (cdb_valid && (cdb_pd == dispatch_ps1));
        new_ent.rdy2     = !is_rr || dispatch_ps2_rdy || (dispatch_ps2 == '0) ||
                           (cdb_valid && (cdb_pd == dispatch_ps2));
    end

    // Next queue: wake, collapse over the issued slot, then append behind the survivors.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woke[i] = ent[i];
            if (cdb_valid && (ent[i].ps1 == cdb_pd)) woke[i].rdy1 = 1'b1;
            if (cdb_valid && (ent[i].ps2 == cdb_pd)) woke[i].rdy2 = 1'b1;
        end
        for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            ent_n[i] = (fire && (IW'(i) >= sel)) ? woke[i+1] : woke[i];
        end
        ent_n[NUM_ENTRIES-1] = woke[NUM_ENTRIES-1];
        wr_idx = cnt - CW'(fire);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (accept && (wr_idx == CW'(i))) ent_n[i] = new_ent;
        end
        cnt_n = cnt + CW'(accept) - CW'(fire);
        if (flush) cnt_n = '0;
    end

    // Queue state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
        end else begin
            cnt <= cnt_n;
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= ent_n[i];
        end
    end

endmodule

// File: tb/tb_rs_add.sv
// Directed bench for rs_add: expected issues are queued as stimulus is applied,
// a negedge monitor pops and compares every FU handshake.
module tb_rs_add;
    import rs_add_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         dispatch_valid;
    logic         dispatch_ready;
    decode_info_t dispatch_info;
    logic [5:0]   dispatch_ps1;
    logic         dispatch_ps1_rdy;
    logic [5:0]   dispatch_ps2;
    logic         dispatch_ps2_rdy;
    logic [5:0]   dispatch_pd;
    logic [4:0]   dispatch_rob;
    logic         cdb_valid;
    logic [5:0]   cdb_pd;
    logic         issue_valid;
    logic         issue_ready;
    decode_info_t issue_info;
    logic [5:0]   issue_ps1;
    logic [5:0]   issue_ps2;
    logic [5:0]   issue_pd;
    logic [4:0]   issue_rob;

    typedef struct packed {
        logic [6:0] op;
        logic [5:0] ps1;
        logic [5:0] ps2;
        logic [5:0] pd;
        logic [4:0] rob;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    rs_add #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(5), .NUM_ENTRIES(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_info(dispatch_info),
        .dispatch_ps1(dispatch_ps1), .dispatch_ps1_rdy(dispatch_ps1_rdy),
        .dispatch_ps2(dispatch_ps2), .dispatch_ps2_rdy(dispatch_ps2_rdy),
        .dispatch_pd(dispatch_pd), .dispatch_rob(dispatch_rob),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_info(issue_info), .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
        .issue_pd(issue_pd), .issue_rob(issue_rob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic disp(input logic [6:0] op, input int ps1, input bit r1,
                        input int ps2, input bit r2, input int pd, input int rob);
        dispatch_valid   = 1'b1;
        dispatch_info    = '{opcode: op, funct3: 3'd0, funct7: 7'd0, imm: 32'(rob), pc: 32'(rob * 4)};
        dispatch_ps1     = 6'(ps1);
        dispatch_ps1_rdy = r1;
        dispatch_ps2     = 6'(ps2);
        dispatch_ps2_rdy = r2;
        dispatch_pd      = 6'(pd);
        dispatch_rob     = 5'(rob);
    endtask

    task automatic expect_issue(input logic [6:0] op, input int ps1, input int ps2,
                                input int pd, input int rob);
        exp_t e;
        e.op  = op;
        e.ps1 = 6'(ps1);
        e.ps2 = 6'(ps2);
        e.pd  = 6'(pd);
        e.rob = 5'(rob);
        sb.push_back(e);
    endtask

    task automatic cdb(input int pd);
        cdb_valid = 1'b1;
        cdb_pd    = 6'(pd);
    endtask

    // Monitor: every accepted issue must match the next queued expectation.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (!rst && !flush && issue_valid && issue_ready) begin
                got = {issue_info.opcode, issue_ps1, issue_ps2, issue_pd, issue_rob};
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_issue: got rob %0d with nothing expected at %0t", issue_rob, $time);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_miss++;
                        $display("FAIL issue_payload: got %h (rob %0d) expected %h (rob %0d) at %0t",
                                 got, issue_rob, e, e.rob, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        issue_ready = 1'b0;
        dispatch_info = '0;
        dispatch_ps1 = '0; dispatch_ps1_rdy = 1'b0;
        dispatch_ps2 = '0; dispatch_ps2_rdy = 1'b0;
        dispatch_pd = '0; dispatch_rob = '0;
        cdb_pd = '0;
        idle();
        tick();
        tick();
        chk("reset_dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Oldest-first: younger ready ADDI passes the waiting ADD, which issues after wakeup.
        issue_ready = 1'b1;
        disp(OPC_OP, 5, 0, 0, 0, 10, 1);
        tick();
        disp(OPC_OP_IMM, 0, 0, 9, 0, 11, 2);
        expect_issue(OPC_OP_IMM, 0, 9, 11, 2);
        tick();
        idle();
        chk("t2_issue_valid_after_dispatch", 32'(issue_valid), 32'd1);
        chk("t2_issue_rob_young", 32'(issue_rob), 32'd2);
        tick();
        cdb(5);
        chk("t2_no_issue_before_wakeup", 32'(issue_valid), 32'd0);
        expect_issue(OPC_OP, 5, 0, 10, 1);
        tick();
        idle();
        chk("t2_woken_issue_valid", 32'(issue_valid), 32'd1);
        tick();
        chk("t2_empty_after", 32'(issue_valid), 32'd0);

        // Full: four waiting ops fill the station; a fifth (ready) op must be dropped.
        for (int k = 0; k < 4; k++) begin
            disp(OPC_OP, 20 + k, 0, 0, 0, 30 + k, 3 + k);
            tick();
        end
        chk("t3_full_dispatch_ready", 32'(dispatch_ready), 32'd0);
        disp(OPC_OP_IMM, 0, 1, 0, 1, 40, 7);
        tick();
        idle();
        chk("t3_still_full", 32'(dispatch_ready), 32'd0);
        chk("t3_nothing_ready", 32'(issue_valid), 32'd0);
        cdb(20);
        expect_issue(OPC_OP, 20, 0, 30, 3);
        tick();
        idle();
        chk("t3_slot0_issue_valid", 32'(issue_valid), 32'd1);
        chk("t3_ready_low_during_issue", 32'(dispatch_ready), 32'd0);
        tick();
        chk("t3_ready_after_issue", 32'(dispatch_ready), 32'd1);
        for (int k = 1; k < 4; k++) begin
            cdb(20 + k);
            expect_issue(OPC_OP, 20 + k, 0, 30 + k, 3 + k);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("t3_drained", 32'(issue_valid), 32'd0);

        // Same-cycle wakeup of the op being dispatched.
        disp(OPC_OP, 0, 0, 7, 0, 13, 8);
        cdb(7);
        expect_issue(OPC_OP, 0, 7, 13, 8);
        tick();
        idle();
        chk("t4_same_cycle_wakeup", 32'(issue_valid), 32'd1);
        tick();
        chk("t4_issued_once", 32'(issue_valid), 32'd0);

        // Backpressure: LUI with non-ready tags is ready anyway and is held stable.
        issue_ready = 1'b0;
        disp(OPC_LUI, 30, 0, 31, 0, 12, 9);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            chk("t5_held_valid", 32'(issue_valid), 32'd1);
            chk("t5_held_rob", 32'(issue_rob), 32'd9);
            chk("t5_held_pd", 32'(issue_pd), 32'd12);
            tick();
        end
        expect_issue(OPC_LUI, 30, 31, 12, 9);
        issue_ready = 1'b1;
        tick();
        chk("t5_fired_once", 32'(issue_valid), 32'd0);

        // Flush with dispatch and issue in the same cycle.
        disp(OPC_OP_IMM, 0, 1, 0, 1, 14, 10);
        tick();
        disp(OPC_OP_IMM, 0, 1, 0, 1, 15, 11);
        flush = 1'b1;
        tick();
        idle();
        chk("t6_no_issue_after_flush", 32'(issue_valid), 32'd0);
        chk("t6_ready_after_flush", 32'(dispatch_ready), 32'd1);
        repeat (2) tick();
        chk("t6_no_phantom", 32'(issue_valid), 32'd0);
        disp(OPC_OP_IMM, 0, 1, 0, 1, 16, 12);
        expect_issue(OPC_OP_IMM, 0, 0, 16, 12);
        tick();
        idle();
        chk("t6_fresh_rob", 32'(issue_rob), 32'd12);
        tick();

        // Asynchronous reset mid-run with a full station holding one ready op.
        issue_ready = 1'b0;
        disp(OPC_OP, 40, 0, 0, 0, 20, 20);
        tick();
        disp(OPC_OP_IMM, 0, 0, 0, 0, 21, 21);
        tick();
        disp(OPC_OP, 41, 0, 0, 0, 22, 22);
        tick();
        disp(OPC_OP, 42, 0, 0, 0, 23, 23);
        tick();
        idle();
        chk("t1_pre_full", 32'(dispatch_ready), 32'd0);
        chk("t1_pre_valid", 32'(issue_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_async_dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("t1_async_issue_valid", 32'(issue_valid), 32'd0);
        chk("t1_async_issue_rob", 32'(issue_rob), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t1_post_issue_valid", 32'(issue_valid), 32'd0);
        chk("t1_post_dispatch_ready", 32'(dispatch_ready), 32'd1);

        chk("all_expected_issues_seen", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
